// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Signal bundle around the shared memory-port arbiter. It
//               carries the instruction-fetch requester, the load/store
//               requester and the single memory port.
//               slave  : arbiter view (requests/responses in, grants out)
//               master : environment view (drives requests and the memory
//                        side responses, observes grants/rvalids)
// Ports       : instr_* : fetch req/addr in, gnt/rvalid/rdata out
//               data_*  : LSU req/addr/we/wdata in, gnt/rvalid/rdata out
//               mem_*   : req/addr/we/wdata out, gnt/rvalid/rdata in
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    // Instruction-fetch requester
    logic                  instr_req_i;
    logic [DATA_WIDTH-1:0] instr_addr_i;
    logic                  instr_gnt_o;
    logic                  instr_rvalid_o;
    logic [DATA_WIDTH-1:0] instr_rdata_o;

    // Load/store requester
    logic                  data_req_i;
    logic [DATA_WIDTH-1:0] data_addr_i;
    logic                  data_we_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic [DATA_WIDTH-1:0] data_rdata_o;

    // Shared memory port
    logic                  mem_req_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_addr_i, data_we_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_addr_i, data_we_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and the
//               load/store unit. Data has priority unless fetch has lost
//               STARVE_LIMIT cycles in a row. A request that is presented
//               but not granted locks the selection until the grant. The
//               source of every granted transaction is kept in an in-order
//               FIFO so each response is routed back to its requester.
// Ports       : clk_i   - clock
//               rst_ni  - synchronous reset, active-low
//               bus     - requester/memory bundle (slave modport)
//               err_o   - sticky: response seen with nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  wire               clk_i,
    input  wire               rst_ni,
    mem_port_arbiter_if.slave bus,
    output logic              err_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_PTR_W-1:0]    c_PTR_LAST   = c_PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_MAX    = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    // Lock state: which source (if any) is pinned until the memory grants
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCK_I = 2'd1;
    localparam logic [1:0] ST_LOCK_D = 2'd2;

    // Source-ID encoding in the FIFO
    localparam logic c_SRC_INSTR = 1'b0;
    localparam logic c_SRC_DATA  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]                 state_q,      state_d;
    logic [c_STARVE_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q,       fifo_d;
    logic [c_PTR_W-1:0]         wr_ptr_q,     wr_ptr_d;
    logic [c_PTR_W-1:0]         rd_ptr_q,     rd_ptr_d;
    logic [c_CNT_W-1:0]         fifo_cnt_q,   fifo_cnt_d;
    logic                       err_q,        err_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                  w_sel_data;
    logic                  w_sel_req;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_mem_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_head;
    logic                  w_instr_gnt;
    logic [DATA_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_mem_we;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_fifo_empty = (fifo_cnt_q == '0);
    assign w_fifo_full  = (fifo_cnt_q == c_CNT_MAX);

    // ------------------------------------------------------------------
    // Source selection
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_data = c_SRC_INSTR;
        case (state_q)
            ST_LOCK_I: w_sel_data = c_SRC_INSTR;
            ST_LOCK_D: w_sel_data = c_SRC_DATA;
            default: begin
                if ((starve_cnt_q == c_STARVE_MAX) && bus.instr_req_i) begin
                    w_sel_data = c_SRC_INSTR;
                end else begin
                    w_sel_data = bus.data_req_i;
                end
            end
        endcase
    end

    assign w_sel_req = w_sel_data ? bus.data_req_i : bus.instr_req_i;

    // A full FIFO may still accept a new request when a response retires
    // an entry in the same cycle.
    assign w_mem_req   = w_sel_req & (~w_fifo_full | bus.mem_rvalid_i);
    assign w_push      = w_mem_req & bus.mem_gnt_i;
    assign w_instr_gnt = w_push & ~w_sel_data;

    // Address/data muxing; forced to zero when the selected source is idle
    // so the port does not leak a stale address.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        if (w_sel_req) begin
            if (w_sel_data) begin
                w_mem_addr  = bus.data_addr_i;
                w_mem_we    = bus.data_we_i;
                w_mem_wdata = bus.data_wdata_i;
            end else begin
                w_mem_addr  = bus.instr_addr_i;
            end
        end
    end

    assign bus.mem_req_o   = w_mem_req;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_wdata_o = w_mem_wdata;
    assign bus.instr_gnt_o = w_instr_gnt;
    assign bus.data_gnt_o  = w_push & w_sel_data;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    // With an empty FIFO a same-cycle grant and response is a bypass: the
    // response belongs to the transaction being pushed right now.
    assign w_head = w_fifo_empty ? w_sel_data : fifo_q[rd_ptr_q];
    assign w_pop  = bus.mem_rvalid_i & (~w_fifo_empty | w_push);

    assign bus.instr_rvalid_o = w_pop & (w_head == c_SRC_INSTR);
    assign bus.data_rvalid_o  = w_pop & (w_head == c_SRC_DATA);
    assign bus.instr_rdata_o  = bus.mem_rdata_i;
    assign bus.data_rdata_o   = bus.mem_rdata_i;

    assign err_o = err_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (bus.mem_gnt_i) begin
            state_d = ST_IDLE;
        end else if (w_mem_req && (state_q == ST_IDLE)) begin
            state_d = w_sel_data ? ST_LOCK_D : ST_LOCK_I;
        end else if ((state_q != ST_LOCK_I) && (state_q != ST_LOCK_D)) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (bus.instr_req_i && !w_instr_gnt) begin
            starve_cnt_d = (starve_cnt_q == c_STARVE_MAX) ? starve_cnt_q
                                                          : starve_cnt_q + 1'b1;
        end
    end

    // Pointer writes during a bypass are harmless: both pointers advance
    // together and the count does not change.
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (w_push) begin
            fifo_d[wr_ptr_q] = w_sel_data;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({w_push, w_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    assign err_d = err_q | (bus.mem_rvalid_i & ~w_pop);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            fifo_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            err_q        <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter. Expected grants and
//               responses are queued by the stimulus; a negedge monitor pops
//               and compares whenever the DUT shows a grant or an rvalid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int DW = 32;

    typedef struct {
        logic          src;
        logic [DW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct {
        logic          src;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic err;

    int checks = 0;
    int errors = 0;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    gnt_t mon_g;
    rsp_t mon_r;

    logic cur_src;
    logic prev_src;

    mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (2),
        .STARVE_LIMIT    (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_gnt(input logic src, input logic [DW-1:0] addr,
                           input logic we, input logic [DW-1:0] wdata);
        gnt_t g;
        g.src = src; g.addr = addr; g.we = we; g.wdata = wdata;
        gnt_q.push_back(g);
    endtask

    task automatic exp_rsp(input logic src, input logic [DW-1:0] rdata);
        rsp_t r;
        r.src = src; r.rdata = rdata;
        rsp_q.push_back(r);
    endtask

    task automatic set_in(input logic ireq, input logic [DW-1:0] iaddr,
                          input logic dreq, input logic [DW-1:0] daddr,
                          input logic dwe,  input logic [DW-1:0] dwd,
                          input logic gnt,  input logic rv, input logic [DW-1:0] rd);
        bus.instr_req_i  = ireq;
        bus.instr_addr_i = iaddr;
        bus.data_req_i   = dreq;
        bus.data_addr_i  = daddr;
        bus.data_we_i    = dwe;
        bus.data_wdata_i = dwd;
        bus.mem_gnt_i    = gnt;
        bus.mem_rvalid_i = rv;
        bus.mem_rdata_i  = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every grant and every response against the queues
    always @(negedge clk) begin
        if (bus.instr_gnt_o || bus.data_gnt_o) begin
            checks++;
            if (gnt_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_gnt: got instr_gnt=%0b data_gnt=%0b addr=0x%08h expected no grant",
                         bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o);
            end else begin
                mon_g = gnt_q.pop_front();
                if ((bus.instr_gnt_o && bus.data_gnt_o) || (bus.data_gnt_o !== mon_g.src) ||
                    (bus.mem_addr_o !== mon_g.addr) || (bus.mem_we_o !== mon_g.we) ||
                    (bus.mem_wdata_o !== mon_g.wdata)) begin
                    errors++;
                    $display("FAIL grant: got ig=%0b dg=%0b addr=0x%08h we=%0b wd=0x%08h expected src=%0b addr=0x%08h we=%0b wd=0x%08h",
                             bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o,
                             mon_g.src, mon_g.addr, mon_g.we, mon_g.wdata);
                end
            end
        end
        if (bus.instr_rvalid_o || bus.data_rvalid_o) begin
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: got instr_rvalid=%0b data_rvalid=%0b expected none",
                         bus.instr_rvalid_o, bus.data_rvalid_o);
            end else begin
                mon_r = rsp_q.pop_front();
                if ((bus.instr_rvalid_o && bus.data_rvalid_o) || (bus.data_rvalid_o !== mon_r.src) ||
                    ((mon_r.src ? bus.data_rdata_o : bus.instr_rdata_o) !== mon_r.rdata)) begin
                    errors++;
                    $display("FAIL response: got irv=%0b drv=%0b irdata=0x%08h drdata=0x%08h expected src=%0b rdata=0x%08h",
                             bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o, bus.data_rdata_o,
                             mon_r.src, mon_r.rdata);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        @(negedge clk);
        chk("rst_err", err, 0);
        chk("rst_mem_req", bus.mem_req_o, 0);
        chk("rst_gnts", {bus.instr_gnt_o, bus.data_gnt_o}, 0);
        chk("rst_rvalids", {bus.instr_rvalid_o, bus.data_rvalid_o}, 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // ---------------- single fetch ----------------
        exp_gnt(0, 32'h100, 0, 0);
        set_in(1, 32'h100, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("fetch_gnt", bus.instr_gnt_o, 1);
        next_cycle();
        exp_rsp(0, 32'hDEADBEEF);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        @(negedge clk);
        chk("fetch_rvalid", bus.instr_rvalid_o, 1);
        chk("fetch_no_data_rvalid", bus.data_rvalid_o, 0);
        next_cycle();

        // ---------------- contention ----------------
        exp_gnt(1, 32'h300, 1, 32'h11223344);
        set_in(1, 32'h200, 1, 32'h300, 1, 32'h11223344, 1, 0, 0);
        @(negedge clk);
        chk("cont_instr_waits", bus.instr_gnt_o, 0);
        next_cycle();
        exp_gnt(0, 32'h200, 0, 0);
        exp_rsp(1, 32'hAAAA0001);
        set_in(1, 32'h200, 0, 0, 0, 0, 1, 1, 32'hAAAA0001);
        next_cycle();
        exp_rsp(0, 32'hBBBB0002);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hBBBB0002);
        next_cycle();

        // ---------------- lock ----------------
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("lock_wait_addr", bus.mem_addr_o, 32'h400);
            chk("lock_wait_req", bus.mem_req_o, 1);
            next_cycle();
        end
        set_in(1, 32'h400, 1, 32'h500, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lock_hold_addr", bus.mem_addr_o, 32'h400);
        chk("lock_data_blocked", bus.data_gnt_o, 0);
        next_cycle();
        exp_gnt(0, 32'h400, 0, 0);
        set_in(1, 32'h400, 1, 32'h500, 0, 0, 1, 0, 0);
        next_cycle();
        exp_gnt(1, 32'h500, 0, 0);
        set_in(0, 0, 1, 32'h500, 0, 0, 1, 0, 0);
        next_cycle();
        exp_rsp(0, 32'hC0000001);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hC0000001);
        next_cycle();
        exp_rsp(1, 32'hC0000002);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hC0000002);
        next_cycle();

        // ---------------- starvation ----------------
        prev_src = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cur_src = (i == 4) ? 1'b0 : 1'b1;
            if (cur_src) exp_gnt(1, 32'h600, 1, 32'hA5A50000);
            else         exp_gnt(0, 32'h700, 0, 0);
            if (i > 0) exp_rsp(prev_src, 32'h50000000 + i);
            set_in(1, 32'h700, 1, 32'h600, 1, 32'hA5A50000, 1, (i > 0), 32'h50000000 + i);
            @(negedge clk);
            chk("starve_instr_gnt", bus.instr_gnt_o, (i == 4));
            next_cycle();
            prev_src = cur_src;
        end
        exp_rsp(prev_src, 32'h50000006);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h50000006);
        next_cycle();

        // ---------------- FIFO full ----------------
        exp_gnt(1, 32'h800, 0, 0);
        set_in(0, 0, 1, 32'h800, 0, 0, 1, 0, 0);
        next_cycle();
        exp_gnt(1, 32'h804, 0, 0);
        set_in(0, 0, 1, 32'h804, 0, 0, 1, 0, 0);
        next_cycle();
        set_in(0, 0, 1, 32'h808, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("full_blocks_req", bus.mem_req_o, 0);
        chk("full_no_gnt", bus.data_gnt_o, 0);
        next_cycle();
        exp_rsp(1, 32'h000000F1);
        exp_gnt(1, 32'h808, 0, 0);
        set_in(0, 0, 1, 32'h808, 0, 0, 1, 1, 32'h000000F1);
        @(negedge clk);
        chk("full_pop_reenables", bus.mem_req_o, 1);
        next_cycle();
        exp_rsp(1, 32'h000000F2);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h000000F2);
        next_cycle();
        exp_rsp(1, 32'h000000F3);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h000000F3);
        next_cycle();

        // ---------------- spurious response / reset ----------------
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h00000BAD);
        @(negedge clk);
        chk("spur_no_rvalid", {bus.instr_rvalid_o, bus.data_rvalid_o}, 0);
        chk("spur_err_not_yet", err, 0);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("spur_err_set", err, 1);
        next_cycle();
        @(negedge clk);
        chk("spur_err_sticky", err, 1);
        next_cycle();
        // leave one transaction outstanding, then reset
        exp_gnt(0, 32'h900, 0, 0);
        set_in(1, 32'h900, 0, 0, 0, 0, 1, 0, 0);
        next_cycle();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h00000077);
        @(negedge clk);
        chk("reset_err_clear", err, 0);
        chk("reset_fifo_empty", {bus.instr_rvalid_o, bus.data_rvalid_o}, 0);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_reset_spur_err", err, 1);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("final_err_clear", err, 0);
        chk("idle_mem_req", bus.mem_req_o, 0);
        next_cycle();

        chk("gnt_queue_drained", gnt_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
